ram_pair_scanner: RTL and testbench
===================================

// Module: ram_pair_scanner
// PURPOSE
//  Read-side sequencer for the paired name/value RAMs (mem0: NAME_W-bit name, mem1: VAL_W-bit value).
//  On start, it walks every address two at a time, driving both read ports of both RAMs.
//  It skips empty entries (name == 0) and streams each non-empty record out over a valid/ready port.
//  It sits directly downstream of the two 2W/2R ram instances; its read ports fan out to both RAMs.
// PARAMETERS
//  ADDRWIDTH  3   RAM address width; DEPTH = 2**ADDRWIDTH; must be >= 1
//  NAME_W     64  mem0 data width (8 chars x 8 bits)
//  VAL_W      8   mem1 data width
// PORTS
//  clk        in   1            clock, all state on posedge
//  rst        in   1            asynchronous, active-high reset
//  start      in   1            scan request; sampled in IDLE only
//  busy       out  1            high from the cycle after start is accepted until DONE inclusive
//  done       out  1            one-cycle pulse at end of scan
//  count      out  ADDRWIDTH+1  records emitted in last/current scan
//  en_r1_n    out  1            read port 1 enable, active-low, to mem0 and mem1
//  addr_r1    out  ADDRWIDTH    read port 1 address (even address)
//  en_r2_n    out  1            read port 2 enable, active-low, to mem0 and mem1
//  addr_r2    out  ADDRWIDTH    read port 2 address (odd address)
//  name_r1    in   NAME_W       mem0 data_r1
//  name_r2    in   NAME_W       mem0 data_r2
//  val_r1     in   VAL_W        mem1 data_r1
//  val_r2     in   VAL_W        mem1 data_r2
//  out_valid  out  1            record available
//  out_ready  in   1            consumer accepts record
//  out_name   out  NAME_W       record name
//  out_val    out  VAL_W        record value
//  out_addr   out  ADDRWIDTH    record address
// BEHAVIOUR
//  - Reset (async, any state): IDLE; busy=0, done=0, count=0, en_r1_n=en_r2_n=1, addr_r1=addr_r2=0,
//    out_valid=0, out_name/out_val/out_addr=0, ptr=0, both slots invalid.
//  - RAM read is asynchronous. Data is sampled at the posedge ending the READ cycle.
//  - FSM IDLE->READ->EMIT0->EMIT1->(READ | DONE)->IDLE.
//  - IDLE:
//    - start=1 -> ptr=0, count=0 -> READ.
//    - start while not IDLE is ignored (not queued).
//  - READ (1 cycle):
//    - en_r1_n=en_r2_n=0, addr_r1=ptr, addr_r2=ptr+1.
//    - At the edge, capture slot0={name_r1,val_r1,ptr} and slot1={name_r2,val_r2,ptr+1}.
//    - slotN.v = (name != 0).
//    - The enables are high in every other state.
//  - EMITn:
//    - out_valid = slotn.v, with out_* = slotn fields.
//    - If slotn.v = 0, leave after exactly 1 cycle.
//    - Otherwise hold until out_valid & out_ready, then count++ and leave.
//    - out_* are stable while out_valid=1 && out_ready=0.
//    - A record whose name is 0 but value is nonzero is still skipped.
//  - After EMIT1: if ptr == DEPTH-2 -> DONE; else ptr += 2 (ADDRWIDTH-bit, no wrap reached) -> READ.
//  - DONE (1 cycle): done=1, busy=1. Then IDLE with busy=0.
//  - count holds its value in IDLE until the next accepted start.
//  - Timing with out_ready=1 throughout: 3 cycles per address pair.
//    - done is high in cycle 3*DEPTH/2+1 after the start edge (13 for ADDRWIDTH=3).
//    - This holds regardless of occupancy.
//    - The first record is valid 2 cycles after the start edge.
//  - Records are emitted in strictly ascending address order.
//  - ADDRWIDTH=1: a single READ covers the whole RAM.
// TESTING
//  T1 load 0:"Nesrine"/FF, 1:"Sridhar"/AA, 2:"Yong"/BB, 3:"Rupkatha"/EE, 4:"Aart"/CC; start, ready=1
//     -> 5 records, addr 0..4 in order, values match; count=5; done at cycle 13.
//  T2 same load; drop ready for 4 cycles while record addr 1 is valid
//     -> out_* stable for those cycles, no duplicates or drops; done at cycle 17; count=5.
//  T3 empty RAMs, start -> out_valid never high; count=0; done at cycle 13; enables low only in 4 READ cycles.
//  T4 addr 5 name=0 with val=0x55; addr 6 "Yong"/BB -> addr 5 skipped; addr 6 emitted.
//  T5 start pulsed again at cycle 5 of a scan -> ignored; exactly one done; count unchanged by the pulse.
//  T6 assert rst while record addr 2 is pending -> same cycle: out_valid=0, busy=0, enables=1, count=0;
//     new start after release -> full correct scan.

Source files
------------

// File: rtl/ram_pair_scanner.sv
// Read-side sequencer for the paired name/value RAMs. It reads two addresses at a time
// and streams every record with a non-zero name out over a valid/ready port.
module ram_pair_scanner #(
  parameter int ADDRWIDTH = 3,
  parameter int NAME_W    = 64,
  parameter int VAL_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [ADDRWIDTH:0]   count,
  output logic                 en_r1_n,
  output logic [ADDRWIDTH-1:0] addr_r1,
  output logic                 en_r2_n,
  output logic [ADDRWIDTH-1:0] addr_r2,
  input  logic [NAME_W-1:0]    name_r1,
  input  logic [NAME_W-1:0]    name_r2,
  input  logic [VAL_W-1:0]     val_r1,
  input  logic [VAL_W-1:0]     val_r2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NAME_W-1:0]    out_name,
  output logic [VAL_W-1:0]     out_val,
  output logic [ADDRWIDTH-1:0] out_addr
);

  localparam int DEPTH = 2 ** ADDRWIDTH;
  localparam int CW    = ADDRWIDTH + 1;
  localparam logic [ADDRWIDTH-1:0] LAST_PTR = ADDRWIDTH'(DEPTH - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EMIT0,
    S_EMIT1,
    S_DONE
  } state_e;

  typedef struct packed {
    logic                 v;
    logic [NAME_W-1:0]    name;
    logic [VAL_W-1:0]     val;
    logic [ADDRWIDTH-1:0] addr;
  } slot_t;

  state_e               state_q, state_d;
  logic [ADDRWIDTH-1:0] ptr_q, ptr_d;
  logic [CW-1:0]        count_q, count_d;
  slot_t                slot0_q, slot0_d;
  slot_t                slot1_q, slot1_d;
  slot_t                cur_slot;

  // NOTE: every register, slots included, is cleared by the async reset so the
  // record outputs read as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    cur_slot  = (state_q == S_EMIT1) ? slot1_q : slot0_q;
    en_r1_n   = 1'b1;
    en_r2_n   = 1'b1;
    addr_r1   = '0;
    addr_r2   = '0;
    done      = 1'b0;
    out_valid = 1'b0;
    out_name  = '0;
    out_val   = '0;
    out_addr  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d   = '0;
          count_d = '0;
          state_d = S_READ;
        end
      end

      S_READ: begin
        en_r1_n       = 1'b0;
        en_r2_n       = 1'b0;
        addr_r1       = ptr_q;
        addr_r2       = ptr_q + ADDRWIDTH'(1);
        slot0_d.v     = (name_r1 != '0);
        slot0_d.name  = name_r1;
        slot0_d.val   = val_r1;
        slot0_d.addr  = ptr_q;
        slot1_d.v     = (name_r2 != '0);
        slot1_d.name  = name_r2;
        slot1_d.val   = val_r2;
        slot1_d.addr  = ptr_q + ADDRWIDTH'(1);
        state_d       = S_EMIT0;
      end

      S_EMIT0, S_EMIT1: begin
        out_valid = cur_slot.v;
        out_name  = cur_slot.name;
        out_val   = cur_slot.val;
        out_addr  = cur_slot.addr;
        // An empty slot costs exactly one cycle so scan length is occupancy-independent.
        if (!cur_slot.v || out_ready) begin
          if (cur_slot.v) count_d = count_q + CW'(1);
          if (state_q == S_EMIT0) begin
            state_d = S_EMIT1;
          end else if (ptr_q == LAST_PTR) begin
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_q + ADDRWIDTH'(2);
            state_d = S_READ;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign count = count_q;

endmodule

// File: tb/tb_ram_pair_scanner.sv
// Bench for ram_pair_scanner: a RAM model feeds the read ports, a table of scans is
// replayed, and a queue scoreboard checks every streamed record.
module tb_ram_pair_scanner;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [3:0]  count;
  logic        en_r1_n;
  logic [2:0]  addr_r1;
  logic        en_r2_n;
  logic [2:0]  addr_r2;
  logic [63:0] name_r1;
  logic [63:0] name_r2;
  logic [7:0]  val_r1;
  logic [7:0]  val_r2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_name;
  logic [7:0]  out_val;
  logic [2:0]  out_addr;

  logic [63:0] name_mem [8];
  logic [7:0]  val_mem  [8];

  assign name_r1 = name_mem[addr_r1];
  assign name_r2 = name_mem[addr_r2];
  assign val_r1  = val_mem[addr_r1];
  assign val_r2  = val_mem[addr_r2];

  ram_pair_scanner #(.ADDRWIDTH(3), .NAME_W(64), .VAL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .count(count),
    .en_r1_n(en_r1_n), .addr_r1(addr_r1), .en_r2_n(en_r2_n), .addr_r2(addr_r2),
    .name_r1(name_r1), .name_r2(name_r2), .val_r1(val_r1), .val_r2(val_r2),
    .out_valid(out_valid), .out_ready(out_ready), .out_name(out_name),
    .out_val(out_val), .out_addr(out_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0][63:0] names;
    logic [7:0][7:0]  vals;
    int stall_addr;
    int stall_len;
    int restart_cyc;
    int exp_count;
    int exp_done;
    int exp_first;
  } vec_t;

  typedef struct {
    logic [63:0] name;
    logic [7:0]  val;
    logic [2:0]  addr;
  } rec_t;

  vec_t vecs [5];
  rec_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, between input changes and the capturing edge.
  logic        hold_v = 1'b0;
  logic [63:0] hold_name;
  logic [7:0]  hold_val;
  logic [2:0]  hold_addr;

  always @(negedge clk) begin
    rec_t e;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", out_valid, 1);
        check("hold_name", out_name, hold_name);
        check("hold_val", out_val, hold_val);
        check("hold_addr", out_addr, hold_addr);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rec: got addr %0d expected none", out_addr);
        end else begin
          e = exp_q.pop_front();
          check("rec_addr", out_addr, e.addr);
          check("rec_name", out_name, e.name);
          check("rec_val", out_val, e.val);
        end
      end
      hold_v    = out_valid && !out_ready;
      hold_name = out_name;
      hold_val  = out_val;
      hold_addr = out_addr;
    end
  end

  task automatic load_vec(input vec_t v);
    rec_t r;
    for (int i = 0; i < 8; i++) begin
      name_mem[i] = v.names[i];
      val_mem[i]  = v.vals[i];
      if (v.names[i] != 64'h0) begin
        r.name = v.names[i];
        r.val  = v.vals[i];
        r.addr = 3'(i);
        exp_q.push_back(r);
      end
    end
  endtask

  // Inputs change 2 time units after each rising edge; k counts cycles after the start edge.
  task automatic run_scan(input int idx);
    vec_t v;
    int   stall_left;
    int   done_k;
    int   done_n;
    int   en_lo;
    int   first_k;
    logic [3:0] cnt_at_done;
    v = vecs[idx];
    load_vec(v);
    stall_left  = v.stall_len;
    done_k      = 0;
    done_n      = 0;
    en_lo       = 0;
    first_k     = 0;
    cnt_at_done = '0;
    @(posedge clk); #2;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      start = (k == v.restart_cyc);
      if (out_valid && out_addr == 3'(v.stall_addr) && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && first_k == 0) first_k = k;
      if (!en_r1_n) en_lo++;
      if (done) begin
        done_n++;
        if (done_k == 0) begin
          done_k      = k;
          cnt_at_done = count;
        end
      end
      if (done_k != 0 && k >= done_k + 4) break;
      @(posedge clk); #2;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check($sformatf("v%0d_done_cycle", idx), done_k, v.exp_done);
    check($sformatf("v%0d_done_pulses", idx), done_n, 1);
    check($sformatf("v%0d_count_at_done", idx), cnt_at_done, v.exp_count);
    check($sformatf("v%0d_count_idle", idx), count, v.exp_count);
    check($sformatf("v%0d_busy_idle", idx), busy, 0);
    check($sformatf("v%0d_read_cycles", idx), en_lo, 4);
    check($sformatf("v%0d_first_valid", idx), first_k, v.exp_first);
    check($sformatf("v%0d_recs_left", idx), exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_en_r1_n"}, en_r1_n, 1);
    check({tag, "_en_r2_n"}, en_r2_n, 1);
    check({tag, "_addr_r1"}, addr_r1, 0);
    check({tag, "_addr_r2"}, addr_r2, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_name"}, out_name, 0);
    check({tag, "_out_val"}, out_val, 0);
    check({tag, "_out_addr"}, out_addr, 0);
  endtask

  initial begin
    logic found;
    for (int i = 0; i < 5; i++) begin
      vecs[i].names       = '0;
      vecs[i].vals        = '0;
      vecs[i].stall_addr  = 0;
      vecs[i].stall_len   = 0;
      vecs[i].restart_cyc = 0;
      vecs[i].exp_count   = 0;
      vecs[i].exp_done    = 13;
      vecs[i].exp_first   = 2;
    end
    // 0: basic five-record load, ready always high
    vecs[0].names[0] = "Nesrine";  vecs[0].vals[0] = 8'hFF;
    vecs[0].names[1] = "Sridhar";  vecs[0].vals[1] = 8'hAA;
    vecs[0].names[2] = "Yong";     vecs[0].vals[2] = 8'hBB;
    vecs[0].names[3] = "Rupkatha"; vecs[0].vals[3] = 8'hEE;
    vecs[0].names[4] = "Aart";     vecs[0].vals[4] = 8'hCC;
    vecs[0].exp_count = 5;
    // 1: same load, ready dropped 4 cycles on record addr 1
    vecs[1] = vecs[0];
    vecs[1].stall_addr = 1;
    vecs[1].stall_len  = 4;
    vecs[1].exp_done   = 17;
    // 2: empty RAM
    vecs[2].exp_first = 0;
    // 3: zero name with non-zero value is skipped
    vecs[3].names[0] = "Aart";     vecs[3].vals[0] = 8'hCC;
    vecs[3].vals[5]  = 8'h55;
    vecs[3].names[6] = "Yong";     vecs[3].vals[6] = 8'hBB;
    vecs[3].exp_count = 2;
    // 4: second start mid-scan is ignored
    vecs[4] = vecs[0];
    vecs[4].restart_cyc = 5;

    for (int i = 0; i < 8; i++) begin
      name_mem[i] = '0;
      val_mem[i]  = '0;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b0;
    #1 rst = 1'b1;
    #3 check_reset_outputs("reset");
    @(posedge clk); #2;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_scan(i);

    // Reset while record addr 2 is waiting on a stalled consumer.
    load_vec(vecs[0]);
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    found = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (out_valid && out_addr == 3'd2) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #2;
    end
    check("t6_rec2_pending", found, 1);
    out_ready = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("t6_reset");
    exp_q.delete();
    @(posedge clk); #2;
    rst       = 1'b0;
    out_ready = 1'b1;
    run_scan(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
